// File: rtl/shift_sub_divider_pkg.sv
// Shared types and next-state helpers for the restoring shift/subtract divider.
// Optional build macro: DIV_ZERO_DETECT_EN. When it is defined, a zero divisor
// finishes on the accept edge instead of running every step.
package div_types;

   localparam int width_p  = 8;
   localparam int iter_w_p = $clog2(width_p + 1);

   typedef logic [width_p-1:0]  operand_t;
   typedef logic [width_p:0]    rem_t;
   typedef logic [iter_w_p-1:0] iter_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SUB   = 2'd2,
      DONE  = 2'd3
   } dop_e;

   // Full architectural state; it is registered as one word.
   typedef struct packed {
      logic     ready;
      logic     done;
      logic     dz;
      dop_e     op;
      iter_t    iteration;
      operand_t m;
      rem_t     a;
      operand_t q;
   } dstate_s;

   // State after reset: idle, every register cleared, ready to accept.
   function automatic dstate_s reset_state();
      dstate_s s;
      s.ready     = 1'b1;
      s.done      = 1'b0;
      s.dz        = 1'b0;
      s.op        = IDLE;
      s.iteration = iter_t'(0);
      s.m         = operand_t'(0);
      s.a         = rem_t'(0);
      s.q         = operand_t'(0);
      return s;
   endfunction

   // State on an accepting edge: latch the operands and clear the partial remainder.
   function automatic dstate_s init_state(input operand_t dividend, input operand_t divisor);
      dstate_s s;
      s.ready     = 1'b0;
      s.done      = 1'b0;
      s.dz        = 1'b0;
      s.op        = SHIFT;
      s.iteration = iter_t'(0);
      s.m         = divisor;
      s.a         = rem_t'(0);
      s.q         = dividend;
`ifdef DIV_ZERO_DETECT_EN
      // A zero divisor jumps straight to the result that the full loop would produce.
      if (divisor == operand_t'(0)) begin
         s.ready = 1'b1;
         s.done  = 1'b1;
         s.dz    = 1'b1;
         s.op    = DONE;
         s.a     = {1'b0, dividend};
         s.q     = {width_p{1'b1}};
      end else begin
         s.dz    = 1'b0;
      end
`endif
      return s;
   endfunction

   // SHIFT: move {A,Q} left by one; the freed quotient bit is filled in SUB.
   function automatic dstate_s shift_state(input dstate_s cur);
      dstate_s s;
      s    = cur;
      s.op = SUB;
      s.a  = {cur.a[width_p-1:0], cur.q[width_p-1]};
      s.q  = {cur.q[width_p-2:0], 1'b0};
      return s;
   endfunction

   // SUB: take the trial-subtract result and quotient bit, then loop or finish.
   function automatic dstate_s sub_state(input dstate_s cur, input rem_t a_next, input logic q_bit);
      dstate_s s;
      s           = cur;
      s.a         = a_next;
      s.q[0]      = q_bit;
      s.iteration = cur.iteration + iter_t'(1);
      if (s.iteration == iter_t'(width_p)) begin
         s.op    = DONE;
         s.ready = 1'b1;
         s.done  = 1'b1;
      end else begin
         s.op    = SHIFT;
      end
      return s;
   endfunction

endpackage

// File: rtl/shift_sub_divider_step_sub.sv
// One restoring-division step: trial subtract of the divisor from the
// partial remainder, keeping the old remainder when the difference is negative.
module div_step_sub
   import div_types::*;
(
   input  rem_t     a,
   input  operand_t m,
   output rem_t     a_next,
   output logic     q_bit
);

   rem_t diff_s;

   assign diff_s = a - {1'b0, m};

   // Restore mux: a set sign bit means the divisor did not fit.
   always_comb begin
      a_next = a;
      q_bit  = 1'b0;
      if (diff_s[width_p]) begin
         a_next = a;
         q_bit  = 1'b0;
      end else begin
         a_next = diff_s;
         q_bit  = 1'b1;
      end
   end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider with a start/ready/done handshake.
// Each quotient bit takes one SHIFT cycle and one SUB cycle.
// Optional build macro: DIV_ZERO_DETECT_EN (adds div_zero_o and an early finish for divisor 0).
module shift_sub_divider
   import div_types::*;
(
   input  logic     clk_i,
   input  logic     reset_n_i,
   input  operand_t dividend_i,
   input  operand_t divisor_i,
   input  logic     start_i,
   output logic     ready_o,
   output operand_t quotient_o,
   output operand_t remainder_o,
`ifdef DIV_ZERO_DETECT_EN
   output logic     div_zero_o,
`endif
   output logic     done_o
);

   dstate_s state_r;
   dstate_s next_s;
   rem_t    a_next_s;
   logic    q_bit_s;
   logic    accept_s;

   // A start request is honoured only while the unit reports ready (IDLE or DONE).
   assign accept_s = start_i & state_r.ready;

   div_step_sub u_step (
      .a      (state_r.a),
      .m      (state_r.m),
      .a_next (a_next_s),
      .q_bit  (q_bit_s)
   );

   // Next-state selection: one helper function per state.
   always_comb begin
      next_s = state_r;
      case (state_r.op)
         IDLE, DONE: begin
            if (accept_s) begin
               next_s = init_state(dividend_i, divisor_i);
            end else begin
               next_s = state_r;
            end
         end
         SHIFT:   next_s = shift_state(state_r);
         SUB:     next_s = sub_state(state_r, a_next_s, q_bit_s);
         default: next_s = reset_state();
      endcase
   end

   // State register; reset aborts any operation in progress at once.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= reset_state();
      end else begin
         state_r <= next_s;
      end
   end

   // All outputs come straight from the registered state.
   assign ready_o     = state_r.ready;
   assign done_o      = state_r.done;
   assign quotient_o  = state_r.q;
   assign remainder_o = state_r.a[width_p-1:0];

`ifdef DIV_ZERO_DETECT_EN
   assign div_zero_o  = state_r.dz;
`else
   logic unused_dz_s;
   assign unused_dz_s = state_r.dz;
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed-vector bench for shift_sub_divider; runs with or without DIV_ZERO_DETECT_EN.
module tb_shift_sub_divider;
   import div_types::*;

   logic     clk_i;
   logic     reset_n_i;
   logic     start_i;
   operand_t dividend_i;
   operand_t divisor_i;
   logic     ready_o;
   logic     done_o;
   operand_t quotient_o;
   operand_t remainder_o;
`ifdef DIV_ZERO_DETECT_EN
   logic     div_zero_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   shift_sub_divider dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .start_i     (start_i),
      .ready_o     (ready_o),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
`ifdef DIV_ZERO_DETECT_EN
      .div_zero_o  (div_zero_o),
`endif
      .done_o      (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present operands with start for one cycle; returns at the negedge after the accept edge.
   task automatic issue(input operand_t dvd, input operand_t dvs);
      @(negedge clk_i);
      dividend_i = dvd;
      divisor_i  = dvs;
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i    = 1'b0;
   endtask

   // Full-latency division with an exact 16-cycle done check.
   task automatic run_div(input string tag, input operand_t dvd, input operand_t dvs,
                          input logic [31:0] eq, input logic [31:0] er);
      issue(dvd, dvs);
      check_eq({tag, ".busy"}, 32'(ready_o), 32'd0);
      repeat (15) @(negedge clk_i);
      check_eq({tag, ".early"}, 32'(done_o), 32'd0);
      @(negedge clk_i);
      check_eq({tag, ".done"},  32'(done_o), 32'd1);
      check_eq({tag, ".ready"}, 32'(ready_o), 32'd1);
      check_eq({tag, ".q"},     32'(quotient_o), eq);
      check_eq({tag, ".r"},     32'(remainder_o), er);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_q;
      int exp_r;
      reset_n_i  = 1'b0;
      start_i    = 1'b0;
      dividend_i = 8'd0;
      divisor_i  = 8'd0;

      // Reset values, held across a clock edge
      #12;
      check_eq("rst.ready", 32'(ready_o), 32'd1);
      check_eq("rst.done",  32'(done_o), 32'd0);
      check_eq("rst.q",     32'(quotient_o), 32'd0);
      check_eq("rst.r",     32'(remainder_o), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
      check_eq("rst.dz",    32'(div_zero_o), 32'd0);
`endif
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // Basic vectors
      run_div("100/7", 8'd100, 8'd7, 32'd14, 32'd2);
      repeat (3) @(negedge clk_i);
      check_eq("hold.done", 32'(done_o), 32'd1);
      check_eq("hold.q",    32'(quotient_o), 32'd14);
      run_div("255/1",   8'd255, 8'd1,   32'd255, 32'd0);
      run_div("5/9",     8'd5,   8'd9,   32'd0,   32'd5);
      run_div("200/200", 8'd200, 8'd200, 32'd1,   32'd0);

      // Start while busy is ignored
      issue(8'd50, 8'd3);
      repeat (4) @(negedge clk_i);
      dividend_i = 8'd9;
      divisor_i  = 8'd9;
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i    = 1'b0;
      check_eq("busy.ready", 32'(ready_o), 32'd0);
      repeat (10) @(negedge clk_i);
      check_eq("busy.early", 32'(done_o), 32'd0);
      @(negedge clk_i);
      check_eq("busy.done", 32'(done_o), 32'd1);
      check_eq("busy.q",    32'(quotient_o), 32'd16);
      check_eq("busy.r",    32'(remainder_o), 32'd2);

      // Asynchronous reset in the middle of an operation
      issue(8'd77, 8'd5);
      repeat (5) @(negedge clk_i);
      #2;
      reset_n_i = 1'b0;
      #1;
      check_eq("arst.ready", 32'(ready_o), 32'd1);
      check_eq("arst.done",  32'(done_o), 32'd0);
      check_eq("arst.q",     32'(quotient_o), 32'd0);
      check_eq("arst.r",     32'(remainder_o), 32'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      run_div("77/5", 8'd77, 8'd5, 32'd15, 32'd2);

      // Divide by zero
`ifdef DIV_ZERO_DETECT_EN
      issue(8'd42, 8'd0);
      check_eq("dz.done",  32'(done_o), 32'd1);
      check_eq("dz.ready", 32'(ready_o), 32'd1);
      check_eq("dz.q",     32'(quotient_o), 32'd255);
      check_eq("dz.r",     32'(remainder_o), 32'd42);
      check_eq("dz.flag",  32'(div_zero_o), 32'd1);
      run_div("dz.next", 8'd100, 8'd7, 32'd14, 32'd2);
      check_eq("dz.clear", 32'(div_zero_o), 32'd0);
`else
      run_div("42/0", 8'd42, 8'd0, 32'd255, 32'd42);
`endif

      // Back-to-back sweep with start held through DONE
      @(negedge clk_i);
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            dividend_i = operand_t'(i * 17);
            divisor_i  = operand_t'(j * 16 + 15);
            start_i    = 1'b1;
            exp_q      = (i * 17) / (j * 16 + 15);
            exp_r      = (i * 17) % (j * 16 + 15);
            @(negedge clk_i);
            check_eq("b2b.restart", 32'(done_o), 32'd0);
            repeat (16) @(negedge clk_i);
            check_eq("b2b.done", 32'(done_o), 32'd1);
            check_eq("b2b.q",    32'(quotient_o), 32'(exp_q));
            check_eq("b2b.r",    32'(remainder_o), 32'(exp_r));
         end
      end
      start_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
